// File: rtl/int_adder_pkg.sv
//==============================================================================
// Module  : int_adder_pkg
// Purpose : Dual-rail constants, FSM state types and completion helpers.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package int_adder_pkg;

  localparam int RAIL_NUM = 2;

  localparam logic [RAIL_NUM-1:0] DR_NULL = 2'b00;
  localparam logic [RAIL_NUM-1:0] DR_0    = 2'b01;
  localparam logic [RAIL_NUM-1:0] DR_1    = 2'b10;
  localparam logic [RAIL_NUM-1:0] DR_ILL  = 2'b11;

  typedef enum logic [0:0] {
    IN_DATA = 1'b0,
    IN_NULL = 1'b1
  } in_state_t;

  typedef enum logic [1:0] {
    OUT_FREE = 2'd0,
    OUT_DATA = 2'd1,
    OUT_NULL = 2'd2
  } out_state_t;

  function automatic logic dr_is_data(input logic [RAIL_NUM-1:0] p);
    return (p == DR_0) || (p == DR_1);
  endfunction

  function automatic logic dr_is_null(input logic [RAIL_NUM-1:0] p);
    return p == DR_NULL;
  endfunction

  function automatic logic dr_is_illegal(input logic [RAIL_NUM-1:0] p);
    return p == DR_ILL;
  endfunction

endpackage

`default_nettype wire

// File: rtl/int_adder_mw_sync.sv
//==============================================================================
// Module  : dr_sync
// Purpose : SYNC_STAGES-deep flop chain bringing inputs into the clk domain.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module dr_sync #(
  parameter int W           = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [SYNC_STAGES-1:0][W-1:0] r_stage;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage <= '0;
    end else begin
      r_stage <= {r_stage[SYNC_STAGES-2:0], d};
    end
  end

  assign q = r_stage[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/int_adder_mw.sv
//==============================================================================
// Module  : int_adder_mw
// Purpose : Multi-word dual-rail (four-phase) adder, LS word first.
//           Optional macro INT_ADDER_MW_ERR_EN adds a sticky illegal-code err.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module int_adder_mw
  import int_adder_pkg::*;
#(
  parameter     ENC         = "TP",
  parameter int WIDTH       = 8,
  parameter int WORDS       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [WIDTH-1:0][RAIL_NUM-1:0]   a,
  input  logic [WIDTH-1:0][RAIL_NUM-1:0]   b,
  output logic                             ack_o,
  output logic [WIDTH-1:0][RAIL_NUM-1:0]   s,
  output logic [RAIL_NUM-1:0]              c_out,
  input  logic                             ack_i
`ifdef INT_ADDER_MW_ERR_EN
  ,
  output logic                             err
`endif
);

  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WORDS - 1);

  generate
    if (ENC != "TP") begin : g_bad_enc
      $fatal(1, "int_adder_mw: only ENC=\"TP\" is supported");
    end
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
      $fatal(1, "int_adder_mw: WIDTH out of range 1..64");
    end
    if (WORDS < 1 || WORDS > 256) begin : g_bad_words
      $fatal(1, "int_adder_mw: WORDS out of range 1..256");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $fatal(1, "int_adder_mw: SYNC_STAGES out of range 2..4");
    end
  endgenerate

  logic [WIDTH-1:0][RAIL_NUM-1:0] w_a_sync, w_b_sync;
  logic                           w_ack_sync;

  dr_sync #(.W(WIDTH*RAIL_NUM), .SYNC_STAGES(SYNC_STAGES)) u_sync_a (
    .clk(clk), .rst_n(rst), .d(a), .q(w_a_sync)
  );
  dr_sync #(.W(WIDTH*RAIL_NUM), .SYNC_STAGES(SYNC_STAGES)) u_sync_b (
    .clk(clk), .rst_n(rst), .d(b), .q(w_b_sync)
  );
  dr_sync #(.W(1), .SYNC_STAGES(SYNC_STAGES)) u_sync_ack (
    .clk(clk), .rst_n(rst), .d(ack_i), .q(w_ack_sync)
  );

  in_state_t                      r_in_state, w_in_next;
  out_state_t                     r_out_state, w_out_next;
  logic [WIDTH-1:0][RAIL_NUM-1:0] r_s, w_s_dr;
  logic [RAIL_NUM-1:0]            r_c, w_c_dr;
  logic [CNT_W-1:0]               r_cnt;
  logic                           r_carry;
  logic                           w_data_cmp, w_null_cmp, w_cin, w_capture;
  logic [WIDTH-1:0]               w_a_bin, w_b_bin;
  logic [WIDTH:0]                 w_sum;

  // Rail 1 is the true rail, so it carries the binary value of a DATA bit.
  always_comb begin
    w_data_cmp = 1'b1;
    w_null_cmp = 1'b1;
    w_a_bin    = '0;
    w_b_bin    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_data_cmp = w_data_cmp & dr_is_data(w_a_sync[i]) & dr_is_data(w_b_sync[i]);
      w_null_cmp = w_null_cmp & dr_is_null(w_a_sync[i]) & dr_is_null(w_b_sync[i]);
      w_a_bin[i] = w_a_sync[i][1];
      w_b_bin[i] = w_b_sync[i][1];
    end
  end

  always_comb begin
    w_cin = (r_cnt == '0) ? 1'b0 : r_carry;
    w_sum = {1'b0, w_a_bin} + {1'b0, w_b_bin} + {{WIDTH{1'b0}}, w_cin};
    w_s_dr = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_s_dr[i] = w_sum[i] ? DR_1 : DR_0;
    end
    w_c_dr = w_sum[WIDTH] ? DR_1 : DR_0;
  end

  assign w_capture = (r_in_state == IN_DATA) && w_data_cmp && (r_out_state == OUT_FREE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_state  <= IN_DATA;
      r_out_state <= OUT_FREE;
    end else begin
      r_in_state  <= w_in_next;
      r_out_state <= w_out_next;
    end
  end

  always_comb begin
    w_in_next  = r_in_state;
    w_out_next = r_out_state;
    case (r_in_state)
      IN_DATA: if (w_capture)  w_in_next = IN_NULL;
      IN_NULL: if (w_null_cmp) w_in_next = IN_DATA;
      default: w_in_next = IN_DATA;
    endcase
    case (r_out_state)
      OUT_FREE: if (w_capture)   w_out_next = OUT_DATA;
      OUT_DATA: if (w_ack_sync)  w_out_next = OUT_NULL;
      OUT_NULL: if (!w_ack_sync) w_out_next = OUT_FREE;
      default:  w_out_next = OUT_FREE;
    endcase
  end

  always_comb begin
    ack_o = (r_in_state == IN_NULL);
    s     = r_s;
    c_out = r_c;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s     <= '0;
      r_c     <= DR_NULL;
      r_cnt   <= '0;
      r_carry <= 1'b0;
    end else if (w_capture) begin
      r_s     <= w_s_dr;
      r_c     <= w_c_dr;
      r_carry <= w_sum[WIDTH];
      r_cnt   <= (r_cnt == C_CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
    end else if (r_out_state == OUT_DATA && w_ack_sync) begin
      r_s <= '0;
      r_c <= DR_NULL;
    end
  end

`ifdef INT_ADDER_MW_ERR_EN
  logic w_illegal;
  logic r_err;

  always_comb begin
    w_illegal = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      w_illegal = w_illegal | dr_is_illegal(w_a_sync[i]) | dr_is_illegal(w_b_sync[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_illegal) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_int_adder_mw.sv
//==============================================================================
// Module  : tb_int_adder_mw
// Purpose : Self-checking bench for int_adder_mw (WIDTH=8, WORDS=2).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_int_adder_mw;

  localparam int SYNC = 2;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  s0;
    logic        c0;
    logic [7:0]  s1;
    logic        c1;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0][1:0] a, b, s;
  logic [1:0]      c_out;
  logic            ack_o, ack_i;
`ifdef INT_ADDER_MW_ERR_EN
  logic            err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  int_adder_mw #(.ENC("TP"), .WIDTH(8), .WORDS(2), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .ack_o(ack_o), .s(s), .c_out(c_out), .ack_i(ack_i)
`ifdef INT_ADDER_MW_ERR_EN
    , .err(err)
`endif
  );

  function automatic logic [15:0] enc8(input logic [7:0] v);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  function automatic logic [1:0] enc1(input logic v);
    return v ? 2'b10 : 2'b01;
  endfunction

  // Reference: whole-operand integer arithmetic, sliced per word.
  task automatic ref_word(input logic [15:0] oa, input logic [15:0] ob, input int w,
                          output logic [7:0] es, output logic ec);
    logic [8:0]  lo;
    logic [16:0] full;
    lo   = {1'b0, oa[7:0]} + {1'b0, ob[7:0]};
    full = {1'b0, oa} + {1'b0, ob};
    if (w == 0) begin es = lo[7:0];     ec = lo[8];    end
    else        begin es = full[15:8];  ec = full[16]; end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_ack(input logic v, input string nm);
    int k = 0;
    while (ack_o !== v && k < 200) begin @(negedge clk); k++; end
    if (ack_o !== v) begin
      n_checks++; n_fail++;
      $display("FAIL %s: timeout, ack_o=%b required %b", nm, ack_o, v);
    end
  endtask

  task automatic wait_s_null(input string nm);
    int k = 0;
    while ((s !== 16'h0 || c_out !== 2'b00) && k < 200) begin @(negedge clk); k++; end
    if (s !== 16'h0 || c_out !== 2'b00) begin
      n_checks++; n_fail++;
      $display("FAIL %s: timeout, s=%h c_out=%b required NULL", nm, s, c_out);
    end
  endtask

  task automatic finish_hs(input string nm);
    a = '0; b = '0; ack_i = 1'b1;
    wait_ack(1'b0, nm);
    wait_s_null(nm);
    ack_i = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
  endtask

  task automatic send_word(input logic [7:0] va, input logic [7:0] vb, input string nm,
                           output logic [15:0] sr, output logic [1:0] cr);
    a = enc8(va); b = enc8(vb);
    wait_ack(1'b1, nm);
    sr = s; cr = c_out;
    finish_hs(nm);
  endtask

  initial begin
    vec_t        tbl [5];
    logic [15:0] sr;
    logic [1:0]  cr;
    logic [7:0]  es;
    logic        ec;
    int          k;

    tbl[0] = '{16'h01FF, 16'h0001, 8'h00, 1'b1, 8'h02, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 8'h00, 1'b1, 8'h00, 1'b1};
    tbl[2] = '{16'h0000, 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[3] = '{16'h0003, 16'h0004, 8'h07, 1'b0, 8'h00, 1'b0};
    tbl[4] = '{16'h80FF, 16'h7F01, 8'h00, 1'b1, 8'h00, 1'b1};

    rst = 1'b0; a = '0; b = '0; ack_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ack_o", {31'b0, ack_o}, 32'd0);
    chk("reset_s", {16'b0, s}, 32'd0);
    chk("reset_c_out", {30'b0, c_out}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      send_word(tbl[i].a[7:0], tbl[i].b[7:0], "tbl_w0", sr, cr);
      chk($sformatf("tbl%0d_s0", i), {16'b0, sr}, {16'b0, enc8(tbl[i].s0)});
      chk($sformatf("tbl%0d_c0", i), {30'b0, cr}, {30'b0, enc1(tbl[i].c0)});
      send_word(tbl[i].a[15:8], tbl[i].b[15:8], "tbl_w1", sr, cr);
      chk($sformatf("tbl%0d_s1", i), {16'b0, sr}, {16'b0, enc8(tbl[i].s1)});
      chk($sformatf("tbl%0d_c1", i), {30'b0, cr}, {30'b0, enc1(tbl[i].c1)});
    end

    // Back-pressure: word1 must wait until the output slot cycles through NULL.
    a = enc8(8'hFF); b = enc8(8'h01);
    wait_ack(1'b1, "bp_w0");
    chk("bp_w0_s", {16'b0, s}, {16'b0, enc8(8'h00)});
    chk("bp_w0_c", {30'b0, c_out}, {30'b0, enc1(1'b1)});
    a = '0; b = '0;
    wait_ack(1'b0, "bp_w0_null");
    a = enc8(8'h10); b = enc8(8'h20);
    repeat (10) @(negedge clk);
    chk("bp_hold_ack", {31'b0, ack_o}, 32'd0);
    chk("bp_hold_s", {16'b0, s}, {16'b0, enc8(8'h00)});
    ack_i = 1'b1;
    wait_s_null("bp_null");
    chk("bp_null_ack", {31'b0, ack_o}, 32'd0);
    ack_i = 1'b0;
    wait_ack(1'b1, "bp_w1");
    chk("bp_w1_s", {16'b0, s}, {16'b0, enc8(8'h31)});
    chk("bp_w1_c", {30'b0, c_out}, {30'b0, enc1(1'b0)});
    finish_hs("bp_w1_done");

    // Partial word then completion: capture SYNC+1 edges after the last bit.
    a = enc8(8'h10); b = '0;
    repeat (10) @(negedge clk);
    chk("part_ack", {31'b0, ack_o}, 32'd0);
    chk("part_s", {16'b0, s}, 32'd0);
    b = enc8(8'h20);
    k = 0;
    do begin @(negedge clk); k++; end while (ack_o !== 1'b1 && k < 20);
    chk("part_latency", k, SYNC + 1);
    chk("part_s_data", {16'b0, s}, {16'b0, enc8(8'h30)});
    finish_hs("part_done");
    send_word(8'h00, 8'h00, "part_w1", sr, cr);
    chk("part_w1_s", {16'b0, sr}, {16'b0, enc8(8'h00)});

    for (int it = 0; it < 20; it++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      for (int w = 0; w < 2; w++) begin
        send_word(ra[8*w +: 8], rb[8*w +: 8], "rand", sr, cr);
        ref_word(ra, rb, w, es, ec);
        chk($sformatf("rand%0d_w%0d_s", it, w), {16'b0, sr}, {16'b0, enc8(es)});
        chk($sformatf("rand%0d_w%0d_c", it, w), {30'b0, cr}, {30'b0, enc1(ec)});
      end
    end

    // Reset after word0 (which left carry=1): next word is word0 again.
    send_word(8'hFF, 8'h01, "rst_w0", sr, cr);
    rst = 1'b0;
    #1;
    chk("midrst_ack", {31'b0, ack_o}, 32'd0);
    chk("midrst_s", {16'b0, s}, 32'd0);
    chk("midrst_c", {30'b0, c_out}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_word(8'h05, 8'h03, "rst_after", sr, cr);
    chk("midrst_w0_s", {16'b0, sr}, {16'b0, enc8(8'h08)});
    chk("midrst_w0_c", {30'b0, cr}, {30'b0, enc1(1'b0)});
    send_word(8'h00, 8'h00, "rst_after_w1", sr, cr);
    chk("midrst_w1_s", {16'b0, sr}, {16'b0, enc8(8'h00)});

`ifdef INT_ADDER_MW_ERR_EN
    chk("err_idle", {31'b0, err}, 32'd0);
    a = enc8(8'h00); a[3] = 2'b11; b = enc8(8'h00);
    repeat (8) @(negedge clk);
    chk("err_set", {31'b0, err}, 32'd1);
    chk("err_no_capture", {31'b0, ack_o}, 32'd0);
    a = '0; b = '0;
    repeat (4) @(negedge clk);
    send_word(8'h01, 8'h02, "err_legal0", sr, cr);
    chk("err_legal0_s", {16'b0, sr}, {16'b0, enc8(8'h03)});
    send_word(8'h00, 8'h00, "err_legal1", sr, cr);
    chk("err_sticky", {31'b0, err}, 32'd1);
    rst = 1'b0;
    #1;
    chk("err_cleared", {31'b0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
